// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B), LSB first, one bit per enabled clock, on the TinyTapeout pin set.
// Optional two's-complement overflow flag on uio_out[4] when SUB_SIGNED_OVF_EN is defined.
module tt_um_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] wa_q, wa_d, wb_q, wb_d;
  logic [WIDTH-1:0] sr_q, sr_d, res_q, res_d;
  logic             bw_q, bw_d, borrow_q, borrow_d, zero_q, zero_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             load_a, load_b, start;
  logic             diff_bit, bw_next;
  logic [WIDTH-1:0] sr_next;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bin);
    sub_bit = {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
  endfunction

  assign load_a = uio_in[7];
  assign load_b = uio_in[6];
  assign start  = uio_in[5];

  always_comb begin
    {bw_next, diff_bit} = sub_bit(wa_q[0], wb_q[0], bw_q);
    sr_next             = sr_q >> 1;
    sr_next[WIDTH-1]    = diff_bit;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    sr_d     = sr_q;
    res_d    = res_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          // A load strobe always takes priority over start in the same cycle.
          if (load_a || load_b) begin
            if (load_a) a_d = ui_in[WIDTH-1:0];
            if (load_b) b_d = ui_in[WIDTH-1:0];
            state_d = IDLE;
          end else if (start) begin
            wa_d    = a_q;
            wb_d    = b_q;
            sr_d    = '0;
            bw_d    = 1'b0;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          wa_d  = wa_q >> 1;
          wb_d  = wb_q >> 1;
          bw_d  = bw_next;
          sr_d  = sr_next;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(WIDTH - 1)) begin
            res_d    = sr_next;
            borrow_d = bw_next;
            zero_d   = (sr_next == '0);
`ifdef SUB_SIGNED_OVF_EN
            ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sr_next[WIDTH-1] != a_q[WIDTH-1]);
`else
            ovf_d    = 1'b0;
`endif
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      sr_q     <= '0;
      res_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      sr_q     <= sr_d;
      res_q    <= res_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    uo_out             = '0;
    uo_out[WIDTH-1:0]  = res_q;
  end

`ifdef SUB_SIGNED_OVF_EN
  assign uio_out = {3'b000, ovf_q, zero_q, borrow_q, state_q == DONE, state_q == SHIFT};
  assign uio_oe  = 8'h1F;
`else
  assign uio_out = {3'b000, 1'b0, zero_q, borrow_q, state_q == DONE, state_q == SHIFT};
  assign uio_oe  = 8'h0F;
  wire unused_ovf = ovf_q;
`endif

  wire unused_pins = &{1'b0, uio_in[4:0], ui_in};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Randomized and directed bench for tt_um_serial_subtractor against an arithmetic reference model.
module tb_tt_um_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] ma, mb;      // model operand registers
  logic [7:0] last_res;    // model of what uo_out currently shows
  int         busy_n;

  tt_um_serial_subtractor #(.WIDTH(8)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    uio_in = 8'h80; ui_in = a; tick();
    uio_in = 8'h40; ui_in = b; tick();
    uio_in = 8'h00;
    ma = a; mb = b;
  endtask

  function automatic logic exp_ovf(input logic [7:0] a, input logic [7:0] b);
`ifdef SUB_SIGNED_OVF_EN
    int sa, sb, d;
    sa = $signed(a); sb = $signed(b); d = sa - sb;
    return (d > 127) || (d < -128);
`else
    return 1'b0;
`endif
  endfunction

  // Start, optionally pause ena and/or fire ignored strobes mid-run, then check the result.
  task automatic run_op(input string tag, input int pause_at, input int pause_len, input int strobe_at);
    logic [7:0] r;
    uio_in = 8'h20; tick(); uio_in = 8'h00;
    busy_n = 0;
    for (int k = 0; k < 100 && uio_out[0] === 1'b1; k++) begin
      busy_n++;
      if (k == 1) chk({tag, "_hold"}, uo_out, last_res);
      ena    = !(k >= pause_at && k < pause_at + pause_len);
      uio_in = (k == strobe_at) ? 8'hE0 : 8'h00;
      ui_in  = (k == strobe_at) ? 8'hFF : ui_in;
      tick();
    end
    ena = 1'b1; uio_in = 8'h00;
    r = ma - mb;
    chk({tag, "_busy"}, busy_n, (pause_len > 0 && pause_at < 8) ? 8 + pause_len : 8);
    chk({tag, "_res"}, uo_out, r);
    chk({tag, "_flags"}, uio_out, {3'b000, exp_ovf(ma, mb), r == 8'h00, ma < mb, 1'b1, 1'b0});
    last_res = r;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    ma = 0; mb = 0; last_res = 0;
    tick();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
`ifdef SUB_SIGNED_OVF_EN
    chk("rst_oe", uio_oe, 8'h1F);
`else
    chk("rst_oe", uio_oe, 8'h0F);
`endif
    rst_n = 1'b1; tick();

    load(8'h5A, 8'h23); run_op("d5a", 100, 0, 100);
    chk("d5a_val", uo_out, 8'h37);
    load(8'h10, 8'h20); run_op("d10", 100, 0, 100);
    chk("d10_val", uo_out, 8'hF0);
    run_op("rerun", 100, 0, 100);
    load(8'h80, 8'h80); run_op("d80", 100, 0, 100);
    chk("d80_zero", uio_out[3], 1'b1);

    // start with load_a in DONE: load wins, leaves DONE, no SHIFT
    uio_in = 8'hA0; ui_in = 8'h44; tick(); uio_in = 8'h00; ma = 8'h44;
    chk("ldst_state", uio_out[1:0], 2'b00);
    tick();
    chk("ldst_idle", uio_out[1:0], 2'b00);
    run_op("ldst", 100, 0, 100);

    // both strobes in one cycle latch the same value
    uio_in = 8'hC0; ui_in = 8'h3C; tick(); uio_in = 8'h00; ma = 8'h3C; mb = 8'h3C;
    run_op("both", 100, 0, 100);

    load(8'h9B, 8'h17);
    run_op("strb", 100, 0, 3);
    run_op("strb2", 100, 0, 100);
    run_op("pause", 2, 3, 100);

    // reset mid-SHIFT abandons the operation and clears A/B
    uio_in = 8'h20; tick(); uio_in = 8'h00;
    tick(); tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mrst_uo", uo_out, 8'h00);
    chk("mrst_uio", uio_out, 8'h00);
    tick();
    chk("mrst_idle", uio_out, 8'h00);
    ma = 0; mb = 0; last_res = 0;
    run_op("zero_ab", 100, 0, 100);

    load(8'h80, 8'h01); run_op("ovf1", 100, 0, 100);
    chk("ovf1_val", uo_out, 8'h7F);
`ifdef SUB_SIGNED_OVF_EN
    chk("ovf1_bit", uio_out[4], 1'b1);
`else
    chk("ovf1_bit", uio_out[4], 1'b0);
`endif
    load(8'h05, 8'h03); run_op("ovf0", 100, 0, 100);
    chk("ovf0_bit", uio_out[4], 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) != 0) load(a, b);
      if ($urandom_range(0, 2) == 0)
        run_op("rnd", $urandom_range(0, 7), $urandom_range(1, 4), $urandom_range(0, 12));
      else
        run_op("rnd", 100, 0, 100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
